avalon_pio_poller: RTL
======================

Name: avalon_pio_poller

Overview:
- Avalon-MM read initiator that periodically polls a PIO-style input slave (e.g. switches/keys) and presents the latest value to fabric logic.
- Issues single-word reads, honours waitrequest, and samples readdata after a fixed read latency.
- Reports value changes as a one-cycle pulse, so consumers need not compare values themselves.
- Sits between a memory-mapped input peripheral and non-processor logic, such as game or control FSMs.

Parameters:
- ADDR_W, 2, width of avm_address.
- DATA_W, 32, width of avm_readdata and value.
- POLL_DIV, 1000, clock cycles between poll starts while enable=1; legal range ≥2.
- READ_LATENCY, 1, cycles from accepted read (avm_read & !avm_waitrequest) to the cycle readdata is sampled; legal range ≥1.
- TIMEOUT_CYCLES, 64, maximum waitrequest stall; used only with POLLER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  periodic polling enable.
- poll_now  in  1  single-cycle request for an immediate poll.
- poll_addr  in  ADDR_W  slave word address; captured at poll start.
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  slave read data.
- value  out  DATA_W  last sampled data.
- value_valid  out  1  high once any poll has completed since reset.
- changed  out  1  one-cycle pulse when a completed poll differs from the previous value; first poll after reset always pulses.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on abort; exists only with POLLER_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - All outputs 0, state=IDLE.
  - Poll timer loaded with POLL_DIV-1; latency counter 0.
  - Reset overrides every state, including mid-read.
  - avm_read drops in the cycle after reset is sampled; any in-flight readdata is ignored.
- Poll timer:
  - Decrements each cycle while enable=1 and state=IDLE.
  - Holds its count while busy; resets to POLL_DIV-1 when enable=0.
  - At 0 it raises an internal tick and reloads.
- IDLE:
  - On tick or poll_now, latch poll_addr into avm_address and go to REQ.
  - Simultaneous tick and poll_now: one poll only.
  - poll_now while busy is dropped, not queued.
- REQ:
  - avm_read=1; avm_address held stable.
  - avm_waitrequest=1: stay in REQ with read and address held.
  - avm_waitrequest=0: read accepted, avm_read=0 next cycle, latency counter loaded with READ_LATENCY-1, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle after the counter reaches 0 (READ_LATENCY cycles after acceptance), sample avm_readdata into value and set value_valid=1.
  - changed=1 for that one cycle if (readdata != value) or value_valid was 0; then return to IDLE.
- Latency example, READ_LATENCY=1: read accepted at edge N, data sampled at edge N+1, value visible after N+1, busy low after N+1.
- No outstanding-read pipelining: exactly one transaction in flight.
- avm_address changes only when entering REQ from IDLE.

Optional Feature:
- POLLER_TIMEOUT_EN defined:
  - A stall counter runs in REQ while avm_waitrequest=1.
  - After TIMEOUT_CYCLES consecutive stall cycles: avm_read=0, timeout_err pulses for 1 cycle, return to IDLE.
  - value, value_valid and changed are unchanged by the abort.
  - Counter clears on entering REQ.
- Not defined:
  - No timeout_err port, no stall counter.
  - REQ waits indefinitely.

Test Plan:
- Reset/defaults: assert reset 3 cycles mid-REQ -> avm_read=0 one cycle after reset is sampled; value=0, value_valid=0, changed=0, busy=0; no poll for POLL_DIV cycles after release with enable=1.
- Basic poll: POLL_DIV=8, READ_LATENCY=1, poll_addr=0, slave returns 0x000000A5 with no stall -> avm_read high exactly 1 cycle every 8 idle cycles; value=0xA5, value_valid=1, changed pulses once.
- Change detect: slave data stays 0xA5 for 2 polls, then becomes 0x3C -> no changed on the repeated 0xA5 poll; changed pulses once with value=0x3C.
- Waitrequest stall: waitrequest=1 for 3 cycles, READ_LATENCY=2 -> avm_read and avm_address stable for 4 cycles; data sampled exactly 2 cycles after acceptance.
- poll_now: pulse poll_now with enable=0 and poll_addr=2 -> one read at address 2; a second poll_now while busy=1 produces no extra read.
- Timeout (POLLER_TIMEOUT_EN, TIMEOUT_CYCLES=4): waitrequest held high -> avm_read drops after 4 stall cycles; timeout_err=1 for one cycle; value unchanged.

Source files
------------

// File: rtl/avalon_pio_poller.sv
// Avalon-MM read initiator that periodically polls a PIO-style slave and exposes the latest word.
// Define POLLER_TIMEOUT_EN to add the waitrequest stall timeout and the timeout_err port.
module avalon_pio_poller #(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 32,
    parameter int POLL_DIV       = 1000,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              poll_now,
    input  logic [ADDR_W-1:0] poll_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    output logic              changed,
    output logic              busy
`ifdef POLLER_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    // state  | meaning
    // S_IDLE | waiting for poll timer tick or poll_now
    // S_REQ  | avm_read asserted, waiting for waitrequest to drop
    // S_WAIT | read accepted, counting down read latency before sampling
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int TMR_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam int LAT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  poll_timer;
    logic [LAT_W-1:0]  lat_cnt;
    logic              tick;
    logic              start;
    logic              accept;
    logic              sample;
    logic              abort;

`ifdef POLLER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    logic [STALL_W-1:0] stall_cnt;
`endif

    assign tick     = enable && (state == S_IDLE) && (poll_timer == '0);
    assign avm_read = (state == S_REQ);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick || poll_now) begin
                    start     = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
`ifdef POLLER_TIMEOUT_EN
                else if (stall_cnt == STALL_LAST) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end
`endif
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timer only runs in IDLE so the poll period excludes bus time.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_timer <= TMR_LOAD;
        end else if (!enable) begin
            poll_timer <= TMR_LOAD;
        end else if (state == S_IDLE) begin
            if (poll_timer == '0) begin
                poll_timer <= TMR_LOAD;
            end else begin
                poll_timer <= poll_timer - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avm_address <= '0;
            lat_cnt     <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            changed     <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (start) begin
                avm_address <= poll_addr;
            end
            if (accept) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == S_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (sample) begin
                value       <= avm_readdata;
                value_valid <= 1'b1;
                changed     <= (avm_readdata != value) || !value_valid;
            end
        end
    end

`ifdef POLLER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (start) begin
                stall_cnt <= '0;
            end else if ((state == S_REQ) && avm_waitrequest && !abort) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = abort;
`endif

endmodule
